display_ctrl: RTL and testbench

Controller that owns the 48-bit `content` bus feeding the 8-digit seven-segment scanner. It accepts register writes from two requesters, the CPU MMIO store path and a system status source, with fixed priority to the system source. It renders either hex values or raw 6-bit glyph codes. It also sequences the time-based effects: blinking, scrolling, and a timed system-message overlay.

---
 rtl/display_pkg.sv | 26 ++
 rtl/display_ctrl_if.sv | 23 ++
 rtl/display_tick_gen.sv | 31 +++
 rtl/display_ctrl.sv | 164 ++++++++++++++++
 tb/tb_display_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, state type and glyph helper for the display controller
package display_pkg;

  localparam logic [5:0] BLANK     = 6'd0;
  localparam logic [5:0] CODE_HEX0 = 6'd1;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RAW_LO = 2'd2;
  localparam logic [1:0] ADDR_RAW_HI = 2'd3;

  localparam int CTRL_MASK_LSB   = 0;
  localparam int CTRL_MASK_MSB   = 7;
  localparam int CTRL_BLINK_BIT  = 8;
  localparam int CTRL_SCROLL_BIT = 9;

  typedef enum logic {
    S_CPU = 1'b0,
    S_SYS = 1'b1
  } state_t;

  function automatic logic [5:0] hex_glyph(input logic [3:0] nib);
    return CODE_HEX0 + {2'b00, nib};
  endfunction

endpackage

// File: rtl/display_ctrl_if.sv
// rtl/display_ctrl_if.sv - CPU/system request bus and rendered content of the display controller
interface display_ctrl_if;

  logic        cpu_valid;
  logic [1:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        sys_valid;
  logic [31:0] sys_data;
  logic        overlay;
  logic [47:0] content;

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, sys_valid, sys_data,
    input  cpu_ready, overlay, content
  );

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, sys_valid, sys_data,
    output cpu_ready, overlay, content
  );

endinterface

// File: rtl/display_tick_gen.sv
// rtl/display_tick_gen.sv - free-running effect tick divider with synchronous clear
module display_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));

  // A clear on the wrap cycle swallows that tick so everything restarts in phase.
  assign o_tick = w_wrap & ~i_clr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// rtl/display_ctrl.sv - owns the 8-digit content bus: register file, effects, system overlay
// i_rst is asynchronous and active-low.
module display_ctrl
  import display_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int HOLD_TICKS = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  display_ctrl_if.slave bus
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic        w_cpu_fire;
  logic        w_ctrl_wr;
  logic        w_tick;

  logic [31:0] r_value;
  logic [47:0] r_raw;
  logic        r_raw_mode;
  logic [7:0]  r_mask;
  logic        r_blink_en;
  logic        r_scroll_en;

  logic [2:0]  r_scroll_off;
  logic        r_blink_ph;

  state_t      r_state;
  logic [HW-1:0] r_hold;
  logic [31:0] r_msg;
  logic        r_overlay;

  logic [7:0][5:0] w_gated;
  logic [47:0] w_next;
  logic [47:0] r_content;

  assign w_cpu_fire    = bus.cpu_valid & ~bus.sys_valid;
  assign w_ctrl_wr     = w_cpu_fire && (bus.cpu_addr == ADDR_CTRL);
  assign bus.cpu_ready = w_cpu_fire;
  assign bus.overlay   = r_overlay;
  assign bus.content   = r_content;

  display_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_ctrl_wr),
    .o_tick(w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_value     <= '0;
      r_raw       <= '0;
      r_raw_mode  <= 1'b0;
      r_mask      <= '0;
      r_blink_en  <= 1'b0;
      r_scroll_en <= 1'b0;
    end else if (w_cpu_fire) begin
      case (bus.cpu_addr)
        ADDR_VALUE: begin
          r_value    <= bus.cpu_wdata;
          r_raw_mode <= 1'b0;
        end
        ADDR_CTRL: begin
          r_mask      <= bus.cpu_wdata[CTRL_MASK_MSB:CTRL_MASK_LSB];
          r_blink_en  <= bus.cpu_wdata[CTRL_BLINK_BIT];
          r_scroll_en <= bus.cpu_wdata[CTRL_SCROLL_BIT];
        end
        ADDR_RAW_LO: begin
          r_raw[31:0] <= bus.cpu_wdata;
          r_raw_mode  <= 1'b1;
        end
        ADDR_RAW_HI: begin
          r_raw[47:32] <= bus.cpu_wdata[15:0];
          r_raw_mode   <= 1'b1;
        end
      endcase
    end
  end

  // Effects keep running during an overlay so the CPU view resumes in step.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_scroll_off <= '0;
      r_blink_ph   <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_scroll_off <= '0;
      r_blink_ph   <= 1'b0;
    end else if (w_tick) begin
      r_blink_ph <= ~r_blink_ph;
      if (r_scroll_en) begin
        r_scroll_off <= r_scroll_off + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_CPU;
      r_hold    <= '0;
      r_msg     <= '0;
      r_overlay <= 1'b0;
    end else begin
      case (r_state)
        S_CPU: begin
          if (bus.sys_valid) begin
            r_state   <= S_SYS;
            r_msg     <= bus.sys_data;
            r_hold    <= HW'(HOLD_TICKS);
            r_overlay <= 1'b1;
          end
        end
        S_SYS: begin
          if (bus.sys_valid) begin
            r_msg  <= bus.sys_data;
            r_hold <= HW'(HOLD_TICKS);
          end else if (w_tick) begin
            if (r_hold == HW'(1)) begin
              r_state   <= S_CPU;
              r_overlay <= 1'b0;
            end else begin
              r_hold <= r_hold - 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Gate each source digit first, then rotate the gated digits by the scroll offset.
  always_comb begin
    w_gated = '0;
    w_next  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!r_mask[i] || (r_blink_en && r_blink_ph)) begin
        w_gated[i] = BLANK;
      end else if (r_raw_mode) begin
        w_gated[i] = r_raw[6*i +: 6];
      end else begin
        w_gated[i] = hex_glyph(r_value[4*i +: 4]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (r_state == S_SYS) begin
        w_next[6*i +: 6] = hex_glyph(r_msg[4*i +: 4]);
      end else begin
        w_next[6*i +: 6] = w_gated[3'(i) - r_scroll_off];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_content <= '0;
    end else begin
      r_content <= w_next;
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
// tb/tb_display_ctrl.sv - self-checking bench for display_ctrl with a reference model
module tb_display_ctrl;

  localparam int TD = 4;
  localparam int HT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  display_ctrl_if bus ();

  display_ctrl #(
    .TICK_DIV  (TD),
    .HOLD_TICKS(HT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_cnt = 0;
  int          m_off = 0;
  int          m_hold = 0;
  bit          m_sys = 0;
  bit          m_ph = 0;
  bit          m_rawmode = 0;
  bit          m_blink = 0;
  bit          m_scroll = 0;
  logic [31:0] m_value = '0;
  logic [31:0] m_msg = '0;
  logic [47:0] m_raw = '0;
  logic [7:0]  m_mask = '0;
  logic [47:0] m_exp = '0;
  bit          m_ovl = 0;

  function automatic logic [47:0] render();
    logic [47:0] r;
    logic [5:0]  g;
    int          s;
    r = '0;
    for (int p = 0; p < 8; p++) begin
      if (m_sys) begin
        g = 6'((m_msg >> (4*p)) & 32'hF) + 6'd1;
      end else begin
        s = (p - m_off + 8) % 8;
        if (m_rawmode) g = 6'((m_raw >> (6*s)) & 48'h3F);
        else           g = 6'((m_value >> (4*s)) & 32'hF) + 6'd1;
        if (!m_mask[s] || (m_blink && m_ph)) g = 6'd0;
      end
      r[6*p +: 6] = g;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit tick;
    bit wr;
    bit cw;
    if (!rst) begin
      m_cnt = 0; m_off = 0; m_hold = 0; m_sys = 0; m_ph = 0;
      m_rawmode = 0; m_blink = 0; m_scroll = 0;
      m_value = '0; m_msg = '0; m_raw = '0; m_mask = '0;
      m_exp = '0; m_ovl = 0;
    end else begin
      wr   = bus.cpu_valid && !bus.sys_valid;
      cw   = wr && (bus.cpu_addr == 2'd1);
      tick = (m_cnt == TD - 1) && !cw;
      m_exp = render();
      if (!m_sys) begin
        if (bus.sys_valid) begin
          m_sys = 1; m_msg = bus.sys_data; m_hold = HT;
        end
      end else if (bus.sys_valid) begin
        m_msg = bus.sys_data; m_hold = HT;
      end else if (tick) begin
        if (m_hold == 1) m_sys = 0;
        else m_hold = m_hold - 1;
      end
      m_ovl = m_sys;
      if (cw) begin
        m_cnt = 0; m_off = 0; m_ph = 0;
      end else begin
        if (tick) begin
          m_ph = !m_ph;
          if (m_scroll) m_off = (m_off + 1) % 8;
        end
        m_cnt = (m_cnt + 1) % TD;
      end
      if (wr) begin
        case (bus.cpu_addr)
          2'd0: begin m_value = bus.cpu_wdata; m_rawmode = 0; end
          2'd1: begin
            m_mask = bus.cpu_wdata[7:0];
            m_blink = bus.cpu_wdata[8];
            m_scroll = bus.cpu_wdata[9];
          end
          2'd2: begin m_raw[31:0] = bus.cpu_wdata; m_rawmode = 1; end
          default: begin m_raw[47:32] = bus.cpu_wdata[15:0]; m_rawmode = 1; end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("content", bus.content, m_exp);
    chk("overlay", 48'(bus.overlay), 48'(m_ovl));
    chk("cpu_ready", 48'(bus.cpu_ready), 48'(bus.cpu_valid & ~bus.sys_valid));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b0;
  endtask

  task automatic sys_pulse(input logic [31:0] d);
    bus.sys_valid = 1'b1;
    bus.sys_data  = d;
    @(posedge clk);
    #1;
    bus.sys_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin
    bit found;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.sys_valid = 1'b0;
    bus.sys_data  = '0;

    step(2);
    chk("rst_content", bus.content, 48'h0);
    chk("rst_overlay", 48'(bus.overlay), 48'h0);
    rst = 1'b1;
    step(1);

    cpu_write(2'd1, 32'h0FF);
    cpu_write(2'd2, 32'h2345_6789);
    cpu_write(2'd3, 32'h0000_ABCD);
    step(1);
    chk("raw_render", bus.content, 48'hABCD_2345_6789);

    cpu_write(2'd0, 32'h1234_ABCD);
    cpu_write(2'd1, 32'h0FF);
    step(1);
    chk("hex_render", bus.content,
        {6'd2, 6'd3, 6'd4, 6'd5, 6'd11, 6'd12, 6'd13, 6'd14});

    cpu_write(2'd1, 32'h10F);
    step(1);
    chk("blink_on", bus.content, {24'h0, 6'd11, 6'd12, 6'd13, 6'd14});
    step(4);
    chk("blink_off", bus.content, 48'h0);
    step(4);
    chk("blink_on2", bus.content, {24'h0, 6'd11, 6'd12, 6'd13, 6'd14});

    cpu_write(2'd0, 32'h0123_4567);
    cpu_write(2'd1, 32'h2FF);
    step(1);
    chk("scroll_t0", bus.content, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8});
    step(4);
    chk("scroll_t1", bus.content, {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd1});
    step(28);
    chk("scroll_t8", bus.content, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8});

    cpu_write(2'd1, 32'h0FF);
    bus.sys_valid = 1'b1;
    bus.sys_data  = 32'hDEAD_BEEF;
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 2'd0;
    bus.cpu_wdata = 32'd5;
    #1;
    chk("arb_ready_lo", 48'(bus.cpu_ready), 48'h0);
    @(posedge clk);
    #1;
    bus.sys_valid = 1'b0;
    #1;
    chk("arb_overlay", 48'(bus.overlay), 48'h1);
    chk("arb_ready_hi", 48'(bus.cpu_ready), 48'h1);
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b0;
    chk("msg_content", bus.content,
        {6'd14, 6'd15, 6'd11, 6'd14, 6'd12, 6'd15, 6'd15, 6'd16});
    for (int k = 0; k < 30 && bus.overlay; k++) step(1);
    chk("expiry_wait", 48'(bus.overlay), 48'h0);
    step(1);
    chk("cpu_view_back", bus.content, {6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd6});

    sys_pulse(32'hCAFE_F00D);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_sys && m_hold == 1 && m_cnt == TD - 1) found = 1;
      else step(1);
    end
    chk("ext_search", 48'(found), 48'h1);
    sys_pulse(32'h0BAD_F00D);
    chk("ext_hold", 48'(bus.overlay), 48'h1);
    step(7);
    chk("ext_still_on", 48'(bus.overlay), 48'h1);
    step(1);
    chk("ext_expired", 48'(bus.overlay), 48'h0);

    cpu_write(2'd1, 32'h2FF);
    step(12);
    sys_pulse(32'h5555_AAAA);
    #2;
    rst = 1'b0;
    #1;
    chk("async_content", bus.content, 48'h0);
    chk("async_overlay", 48'(bus.overlay), 48'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.sys_valid = 1'b1;
    bus.sys_data  = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus.sys_valid = 1'b0;
    step(6);
    chk("post_rst_on", 48'(bus.overlay), 48'h1);
    step(1);
    chk("post_rst_tick", 48'(bus.overlay), 48'h0);

    step(2);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
